// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - shift-add multiply sequencer driving Load/Ad/Sh/Neg of the product datapath
module mult_sequencer #(
   parameter int N = 32
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Req,
   input  logic Signed,
   input  logic A_sign,
   input  logic B_sign,
   input  logic M,
   input  logic Rd_HiLo,
   input  logic Abort,
   output logic Busy,
   output logic Ack,
   output logic Load,
   output logic Ad,
   output logic Sh,
   output logic Neg,
   output logic HiLo_We,
   output logic Done,
   output logic Stall
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_BIT   = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_FIX   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_q, neg_d;
   logic          shift_go;

   assign Busy  = (state_q != S_IDLE);
   assign Stall = Busy & (Rd_HiLo | Req);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      shift_go = 1'b0;
      Ack      = 1'b0;
      Load     = 1'b0;
      Ad       = 1'b0;
      Sh       = 1'b0;
      Neg      = 1'b0;
      HiLo_We  = 1'b0;
      Done     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (Req) begin
               state_d = S_LOAD;
               neg_d   = Signed & (A_sign ^ B_sign);
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            Load    = 1'b1;
            Ack     = 1'b1;
            state_d = S_BIT;
         end
         S_BIT: begin
            if (M) begin
               Ad      = 1'b1;
               state_d = S_SHIFT;
            end else begin
               shift_go = 1'b1;
            end
         end
         S_SHIFT: shift_go = 1'b1;
         S_FIX: begin
            Neg     = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            HiLo_We = 1'b1;
            Done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // The last shift of a run decides between the sign fix-up and completion.
      if (shift_go) begin
         Sh = 1'b1;
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = neg_q ? S_FIX : S_DONE;
         end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_BIT;
         end
      end

      if (Abort && Busy) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         Neg     = 1'b0;
         HiLo_We = 1'b0;
         Done    = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
      end
   end
endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - bench for mult_sequencer with N=4 and N=32 instances and a product-register model
module tb_mult_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst, req, sgn, asg, bsg, m, rd, ab;
   logic [1:0] busy, ack, load, ad, sh, neg, we, done, stall;

   mult_sequencer #(.N(4)) u_n4 (
      .Clk(clk), .Rst(rst[0]), .Req(req[0]), .Signed(sgn[0]), .A_sign(asg[0]), .B_sign(bsg[0]),
      .M(m[0]), .Rd_HiLo(rd[0]), .Abort(ab[0]), .Busy(busy[0]), .Ack(ack[0]), .Load(load[0]),
      .Ad(ad[0]), .Sh(sh[0]), .Neg(neg[0]), .HiLo_We(we[0]), .Done(done[0]), .Stall(stall[0])
   );
   mult_sequencer #(.N(32)) u_n32 (
      .Clk(clk), .Rst(rst[1]), .Req(req[1]), .Signed(sgn[1]), .A_sign(asg[1]), .B_sign(bsg[1]),
      .M(m[1]), .Rd_HiLo(rd[1]), .Abort(ab[1]), .Busy(busy[1]), .Ack(ack[1]), .Load(load[1]),
      .Ad(ad[1]), .Sh(sh[1]), .Neg(neg[1]), .HiLo_We(we[1]), .Done(done[1]), .Stall(stall[1])
   );

   // Product register: bit 2N holds the carry out of an add until the next shift.
   logic [64:0] pr [2];
   logic [31:0] amag [2];
   logic [31:0] bmag [2];
   assign m[0] = pr[0][0];
   assign m[1] = pr[1][0];

   function automatic logic [64:0] dp_step(input logic [64:0] p, input int n, input logic ld,
                                           input logic a_, input logic s_, input logic g_,
                                           input logic [31:0] am, input logic [31:0] bm);
      logic [64:0] mask;
      mask = (65'd1 << (2 * n)) - 65'd1;
      if (ld) return {33'd0, bm};
      if (a_) return p + ({33'd0, am} << n);
      if (s_) return p >> 1;
      if (g_) return (~p + 65'd1) & mask;
      return p;
   endfunction

   always @(posedge clk) begin
      pr[0] <= dp_step(pr[0], 4, load[0], ad[0], sh[0], neg[0], amag[0], bmag[0]);
      pr[1] <= dp_step(pr[1], 32, load[1], ad[1], sh[1], neg[1], amag[1], bmag[1]);
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_s(input string nm, input string act, input string exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %s want %s", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] outs(input int i);
      return {busy[i], ack[i], load[i], ad[i], sh[i], neg[i], we[i], done[i], stall[i]};
   endfunction

   function automatic logic [31:0] nmask(input int n);
      return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
   endfunction

   function automatic logic [63:0] pmask(input int n);
      return (n == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * n)) - 64'd1);
   endfunction

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input int n);
      longint sa, sb;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[n-1]) sa = sa - (longint'(1) << n);
      if (s && b[n-1]) sb = sb - (longint'(1) << n);
      return 64'(sa * sb) & pmask(n);
   endfunction

   function automatic logic [31:0] mag(input logic [31:0] v, input logic s, input int n);
      return (s && v[n-1]) ? ((~v + 32'd1) & nmask(n)) : v;
   endfunction

   typedef struct {
      string       seq;
      int          bcnt;
      int          nad;
      int          nsh;
      int          ndone;
      int          nack;
      int          bad_stall;
      int          bad_excl;
      logic [63:0] prod;
      bit          fin;
   } res_t;

   task automatic run_op(input int i, input logic [31:0] a_in, input logic [31:0] b_in,
                         input logic s, input logic rdv, input int abort_at, input int req_at,
                         output res_t r);
      int n;
      logic [31:0] a, b;
      n = (i == 0) ? 4 : 32;
      a = a_in & nmask(n);
      b = b_in & nmask(n);
      r = '{seq: "", bcnt: 0, nad: 0, nsh: 0, ndone: 0, nack: 0, bad_stall: 0, bad_excl: 0,
            prod: 64'd0, fin: 1'b0};
      amag[i] = mag(a, s, n);
      bmag[i] = mag(b, s, n);
      @(negedge clk);
      req[i] = 1'b1; sgn[i] = s; asg[i] = a[n-1]; bsg[i] = b[n-1]; rd[i] = rdv; ab[i] = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         req[i] = (c == req_at);
         ab[i]  = (c == abort_at);
         #1;
         if (stall[i] !== (busy[i] & (rd[i] | req[i]))) r.bad_stall++;
         if (!busy[i]) begin
            r.fin = 1'b1;
            break;
         end
         r.bcnt++;
         if (load[i]) r.seq = {r.seq, "L"};
         if (ad[i])   r.seq = {r.seq, "A"};
         if (sh[i])   r.seq = {r.seq, "S"};
         if (neg[i])  r.seq = {r.seq, "N"};
         if (we[i])   r.seq = {r.seq, "W"};
         if (int'(load[i]) + int'(ad[i]) + int'(sh[i]) + int'(neg[i]) > 1) r.bad_excl++;
         if (done[i] !== we[i]) r.bad_excl++;
         if (we[i]) r.prod = pr[i][63:0] & pmask(n);
         r.nad   += int'(ad[i]);
         r.nsh   += int'(sh[i]);
         r.ndone += int'(done[i]);
         r.nack  += int'(ack[i]);
      end
      req[i] = 1'b0; rd[i] = 1'b0; ab[i] = 1'b0;
      chk("op terminated", r.fin, 1);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] prod;
      int          busy_cycles;
   } vec_t;

   vec_t  vt [4];
   string vseq [4];
   res_t  r;
   int    done_at, ack2_at, cyc;
   logic [31:0] ra, rb;
   logic        rs;

   initial begin
      rst = 2'b11; req = '0; sgn = '0; asg = '0; bsg = '0; rd = '0; ab = '0;
      repeat (2) @(negedge clk);
      rst = 2'b00;
      #1;
      chk("reset outputs n4", outs(0), 0);
      chk("reset outputs n32", outs(1), 0);

      vt[0] = '{a: 32'd5, b: 32'hB, s: 1'b0, prod: 64'd55,   busy_cycles: 9};
      vt[1] = '{a: 32'hD, b: 32'h2, s: 1'b1, prod: 64'hFA,   busy_cycles: 8};
      vt[2] = '{a: 32'h8, b: 32'h8, s: 1'b1, prod: 64'h40,   busy_cycles: 7};
      vt[3] = '{a: 32'h3, b: 32'hF, s: 1'b1, prod: 64'hFD,   busy_cycles: 8};
      vseq[0] = "LASASSASW";
      vseq[1] = "LSASSSNW";
      vseq[2] = "LSSSASW";
      vseq[3] = "LASSSSNW";
      for (int k = 0; k < 4; k++) begin
         run_op(0, vt[k].a, vt[k].b, vt[k].s, 1'b0, -1, -1, r);
         chk_s($sformatf("vec%0d sequence", k), r.seq, vseq[k]);
         chk($sformatf("vec%0d product", k), r.prod, vt[k].prod);
         chk($sformatf("vec%0d busy", k), r.bcnt, vt[k].busy_cycles);
         chk($sformatf("vec%0d exclusive", k), r.bad_excl, 0);
      end

      // Reset while in SHIFT (cycle 2 of 5 * 4'b1011).
      amag[0] = 32'd5; bmag[0] = 32'hB;
      @(negedge clk);
      req[0] = 1'b1; sgn[0] = 1'b0; asg[0] = 1'b0; bsg[0] = 1'b1;
      @(negedge clk); req[0] = 1'b0;
      @(negedge clk);
      @(negedge clk); rst[0] = 1'b1; #1;
      chk("pre-reset in shift", sh[0], 1);
      @(negedge clk); rst[0] = 1'b0; #1;
      chk("post-reset outputs", outs(0), 0);
      run_op(0, 32'd5, 32'hB, 1'b0, 1'b0, -1, -1, r);
      chk("after reset product", r.prod, 55);
      chk("after reset busy", r.bcnt, 9);

      // Hazard: MFHI/MFLO pending throughout, plus a stray Req while busy.
      run_op(0, 32'd5, 32'hB, 1'b0, 1'b1, -1, 4, r);
      chk("hazard stall", r.bad_stall, 0);
      chk("hazard single ack", r.nack, 1);
      chk("hazard product", r.prod, 55);

      run_op(0, 32'd5, 32'hB, 1'b0, 1'b0, 3, -1, r);
      chk_s("abort bit sequence", r.seq, "LASA");
      chk("abort bit busy", r.bcnt, 4);
      chk("abort bit done", r.ndone, 0);
      run_op(0, 32'hD, 32'h2, 1'b1, 1'b0, 6, -1, r);
      chk_s("abort fix sequence", r.seq, "LSASSS");
      chk("abort fix done", r.ndone, 0);
      run_op(0, 32'hD, 32'h2, 1'b1, 1'b0, 7, -1, r);
      chk_s("abort done sequence", r.seq, "LSASSSN");
      chk("abort done done", r.ndone, 0);
      run_op(0, 32'd5, 32'hB, 1'b0, 1'b0, -1, -1, r);
      chk("after abort product", r.prod, 55);
      chk("after abort busy", r.bcnt, 9);

      // Back-to-back: Req held through DONE.
      amag[0] = 32'd0; bmag[0] = 32'd0;
      done_at = -1; ack2_at = -1; cyc = 0;
      @(negedge clk);
      req[0] = 1'b1; sgn[0] = 1'b0; asg[0] = 1'b0; bsg[0] = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (done[0] && done_at < 0) done_at = c;
         if (ack[0] && done_at >= 0) begin
            ack2_at = c;
            break;
         end
      end
      req[0] = 1'b0;
      chk("back-to-back gap", ack2_at - done_at, 2);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (!busy[0]) break;
      end
      chk("back-to-back idle", busy[0], 0);

      for (int k = 0; k < 2; k++) begin
         ra = $urandom;
         run_op(1, ra, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, -1, r);
         chk("all-ones busy", r.bcnt, 66);
         chk("all-ones ad", r.nad, 32);
         chk("all-ones sh", r.nsh, 32);
         chk("all-ones product", r.prod, ref_prod(ra, 32'hFFFF_FFFF, 1'b0, 32));
         run_op(1, ra, 32'd0, 1'b0, 1'b0, -1, -1, r);
         chk("zero busy", r.bcnt, 34);
         chk("zero ad", r.nad, 0);
         chk("zero product", r.prod, 0);
      end

      for (int k = 0; k < 16; k++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         run_op(1, ra, rb, rs, 1'($urandom_range(0, 1)), -1, -1, r);
         chk($sformatf("rnd%0d product", k), r.prod, ref_prod(ra, rb, rs, 32));
         chk($sformatf("rnd%0d busy", k), r.bcnt,
             34 + $countones(mag(rb, rs, 32)) + int'(rs & (ra[31] ^ rb[31])));
         chk($sformatf("rnd%0d ad", k), r.nad, $countones(mag(rb, rs, 32)));
         chk($sformatf("rnd%0d sh", k), r.nsh, 32);
         chk($sformatf("rnd%0d done", k), r.ndone, 1);
         chk($sformatf("rnd%0d stall", k), r.bad_stall, 0);
         chk($sformatf("rnd%0d exclusive", k), r.bad_excl, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
